// File: rtl/call_stack.sv
// Return-address stack for the memory stage: push on CALL, pop on RET,
// registered pop result, occupancy tracking and sticky overflow/underflow flags.
module call_stack #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  clear_errors,
  output logic [ADDR_WIDTH-1:0] pop_addr,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int IDX_WIDTH = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_reg [DEPTH];
  logic [CNT_WIDTH-1:0]  sp_reg, sp_next;
  logic [ADDR_WIDTH-1:0] pop_addr_reg;
  logic                  pop_valid_reg;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;

  logic                  push_ok, pop_ok, push_ovf, pop_unf;
  logic [CNT_WIDTH-1:0]  sp_minus_one;
  logic [IDX_WIDTH-1:0]  wr_idx, top_idx;

  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == CNT_WIDTH'(DEPTH));

  // Gating by full/empty is what keeps sp from ever wrapping.
  assign push_ok  = enable &  wen & ~full;
  assign push_ovf = enable &  wen &  full;
  assign pop_ok   = enable & ~wen & ~empty;
  assign pop_unf  = enable & ~wen &  empty;

  assign sp_minus_one = sp_reg - CNT_WIDTH'(1);
  assign wr_idx       = sp_reg[IDX_WIDTH-1:0];
  assign top_idx      = sp_minus_one[IDX_WIDTH-1:0];

  always_comb begin
    sp_next = sp_reg;
    if (push_ok)
      sp_next = sp_reg + CNT_WIDTH'(1);
    else if (pop_ok)
      sp_next = sp_minus_one;
  end

  // A fresh error event in the same cycle beats clear_errors.
  always_comb begin
    overflow_next  = clear_errors ? 1'b0 : overflow_reg;
    underflow_next = clear_errors ? 1'b0 : underflow_reg;
    if (push_ovf)
      overflow_next = 1'b1;
    if (pop_unf)
      underflow_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      sp_reg        <= '0;
      pop_addr_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg         <= sp_next;
      pop_valid_reg  <= pop_ok;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
      if (pop_ok)
        pop_addr_reg <= mem_reg[top_idx];
    end
  end

  // Storage has no reset; entries are only meaningful below sp.
  always_ff @(posedge clock) begin
    if (nreset && push_ok)
      mem_reg[wr_idx] <= push_addr;
  end

  assign top_addr  = empty ? '0 : mem_reg[top_idx];
  assign count     = sp_reg;
  assign pop_addr  = pop_addr_reg;
  assign pop_valid = pop_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack with DEPTH=4: reset, LIFO order, overflow,
// underflow, clear-vs-event priority and push/pop interleave at full width.
module tb_call_stack;

  localparam int DEPTH = 4;
  localparam int AW    = 14;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          nreset;
  logic          enable;
  logic          wen;
  logic [AW-1:0] push_addr;
  logic          clear_errors;
  logic [AW-1:0] pop_addr;
  logic          pop_valid;
  logic [AW-1:0] top_addr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int vectors     = 0;
  int miscompares = 0;

  call_stack #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .nreset(nreset), .enable(enable), .wen(wen),
    .push_addr(push_addr), .clear_errors(clear_errors),
    .pop_addr(pop_addr), .pop_valid(pop_valid), .top_addr(top_addr),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Apply one set of inputs for one edge, then settle 1ns past the edge.
  task automatic drive(input logic en, input logic w, input logic [AW-1:0] a,
                       input logic clr);
    enable       = en;
    wen          = w;
    push_addr    = a;
    clear_errors = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    nreset = 1'b1;
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), 1'b0);
    nreset = 1'b0;
    drive(1'b1, 1'b1, 14'h1234, 1'b0);
    drive(1'b1, 1'b0, 14'h0000, 1'b0);
    nreset = 1'b1;
    enable = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (pop_addr !== 14'h0) begin miscompares++; $display("FAIL reset_pop_addr got %h want 0000", pop_addr); end
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b want 0", underflow); end
    vectors++; if (top_addr !== 14'h0) begin miscompares++; $display("FAIL reset_top_addr got %h want 0000", top_addr); end
    $display("test_reset: count=%0d empty=%b pop_addr=%h", count, empty, pop_addr);
  endtask

  task automatic test_lifo;
    logic [AW-1:0] exp_pop [3];
    exp_pop[0] = 14'h0300; exp_pop[1] = 14'h0200; exp_pop[2] = 14'h0100;
    drive(1'b1, 1'b1, 14'h0100, 1'b0);
    vectors++; if (count !== 3'd1 || top_addr !== 14'h0100) begin miscompares++; $display("FAIL lifo_push1 got count=%0d top=%h want 1/0100", count, top_addr); end
    drive(1'b1, 1'b1, 14'h0200, 1'b0);
    drive(1'b1, 1'b1, 14'h0300, 1'b0);
    vectors++; if (count !== 3'd3 || top_addr !== 14'h0300) begin miscompares++; $display("FAIL lifo_push3 got count=%0d top=%h want 3/0300", count, top_addr); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 14'h0, 1'b0);
      vectors++; if (pop_addr !== exp_pop[i] || pop_valid !== 1'b1 || count !== CW'(2 - i)) begin
        miscompares++; $display("FAIL lifo_pop%0d got addr=%h valid=%b count=%0d want %h/1/%0d", i, pop_addr, pop_valid, count, exp_pop[i], 2 - i);
      end
      $display("test_lifo: pop %0d addr=%h valid=%b count=%0d", i, pop_addr, pop_valid, count);
    end
    drive(1'b0, 1'b0, 14'h0, 1'b0);
    vectors++; if (empty !== 1'b1 || pop_valid !== 1'b0 || pop_addr !== 14'h0100) begin miscompares++; $display("FAIL lifo_end got empty=%b valid=%b addr=%h want 1/0/0100", empty, pop_valid, pop_addr); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 1'b1, AW'(i), 1'b0);
    vectors++; if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_full got full=%b count=%0d ovf=%b want 1/4/0", full, count, overflow); end
    drive(1'b1, 1'b1, 14'h3FFF, 1'b0);
    vectors++; if (overflow !== 1'b1 || count !== 3'd4 || top_addr !== 14'h0004) begin miscompares++; $display("FAIL ovf_drop got ovf=%b count=%0d top=%h want 1/4/0004", overflow, count, top_addr); end
    $display("test_overflow: ovf=%b count=%0d top=%h", overflow, count, top_addr);
    for (int i = 4; i >= 1; i--) begin
      drive(1'b1, 1'b0, 14'h0, 1'b0);
      vectors++; if (pop_addr !== AW'(i) || pop_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_pop got addr=%h valid=%b want %h/1", pop_addr, pop_valid, AW'(i)); end
    end
    drive(1'b0, 1'b0, 14'h0, 1'b1);
    vectors++; if (overflow !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL ovf_clear got ovf=%b empty=%b want 0/1", overflow, empty); end
  endtask

  task automatic test_underflow;
    drive(1'b1, 1'b0, 14'h0, 1'b0);
    vectors++; if (underflow !== 1'b1 || pop_valid !== 1'b0 || pop_addr !== 14'h0001 || count !== 3'd0) begin
      miscompares++; $display("FAIL unf_pop got unf=%b valid=%b addr=%h count=%0d want 1/0/0001/0", underflow, pop_valid, pop_addr, count);
    end
    $display("test_underflow: unf=%b valid=%b addr=%h", underflow, pop_valid, pop_addr);
    drive(1'b0, 1'b0, 14'h0, 1'b1);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL unf_clear got %b want 0", underflow); end
  endtask

  task automatic test_clear_vs_event;
    drive(1'b1, 1'b0, 14'h0, 1'b1);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL clr_vs_unf got %b want 1", underflow); end
    $display("test_clear_vs_event: unf=%b", underflow);
    drive(1'b0, 1'b0, 14'h0, 1'b1);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL clr_after got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 14'h3FFF, 1'b0);
    drive(1'b1, 1'b0, 14'h1111, 1'b0);
    vectors++; if (pop_addr !== 14'h3FFF || pop_valid !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL b2b_pop1 got addr=%h valid=%b count=%0d want 3FFF/1/0", pop_addr, pop_valid, count); end
    drive(1'b0, 1'b1, 14'h1555, 1'b0);
    vectors++; if (pop_addr !== 14'h3FFF || pop_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL b2b_idle1 got addr=%h valid=%b count=%0d want 3FFF/0/0", pop_addr, pop_valid, count); end
    drive(1'b1, 1'b1, 14'h2AAA, 1'b0);
    vectors++; if (top_addr !== 14'h2AAA || count !== 3'd1) begin miscompares++; $display("FAIL b2b_push2 got top=%h count=%0d want 2AAA/1", top_addr, count); end
    drive(1'b1, 1'b0, 14'h0, 1'b0);
    vectors++; if (pop_addr !== 14'h2AAA || pop_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_pop2 got addr=%h valid=%b want 2AAA/1", pop_addr, pop_valid); end
    drive(1'b0, 1'b0, 14'h0, 1'b0);
    vectors++; if (pop_addr !== 14'h2AAA || pop_valid !== 1'b0 || count !== 3'd0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL b2b_idle2 got addr=%h valid=%b count=%0d unf=%b want 2AAA/0/0/0", pop_addr, pop_valid, count, underflow);
    end
    $display("test_back_to_back: addr=%h valid=%b count=%0d", pop_addr, pop_valid, count);
  endtask

  initial begin
    nreset       = 1'b0;
    enable       = 1'b0;
    wen          = 1'b0;
    push_addr    = '0;
    clear_errors = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_clear_vs_event();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
